// File: rtl/sub_pkg.sv
// Shared definitions for the serial nibble subtractor: nibble width and FSM encoding.
package sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sub.sv
// Combinational 4-bit borrow-ripple subtractor: d = x - y - bi, bo = borrow out.
module nibble_sub
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                bi,
    output logic [NIBBLE_W-1:0] d,
    output logic                bo
);

    logic [NIBBLE_W:0] w_b;

    assign w_b[0] = bi;

    // Each bit owns its slice of the borrow chain, the top bit included.
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
        assign d[gi]     = x[gi] ^ y[gi] ^ w_b[gi];
        assign w_b[gi+1] = (~(x[gi] ^ y[gi]) & w_b[gi]) | (~x[gi] & y[gi]);
    end

    assign bo = w_b[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_sub.sv
// Wide subtractor that streams one nibble per clock through a single nibble_sub,
// chaining the borrow through a register; start/busy/done handshake.
module serial_nibble_sub
    import sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        bin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] diff,
    output logic                        bout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_borrow;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_work;
    logic [W-1:0]       r_diff;
    logic               r_bout;

    logic               w_accept;
    logic               w_last;
    logic [NIBBLE_W-1:0] w_x;
    logic [NIBBLE_W-1:0] w_y;
    logic [NIBBLE_W-1:0] w_d;
    logic               w_bo;
    logic [W-1:0]       w_work_next;
    logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

    // Operand nibbles are selected by idx; the work word gets only nibble idx replaced.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
        assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
        assign w_work_next[gi*NIBBLE_W +: NIBBLE_W] =
            (r_idx == IDX_W'(gi)) ? w_d : r_work[gi*NIBBLE_W +: NIBBLE_W];
    end

    assign w_x = w_a_nib[r_idx];
    assign w_y = w_b_nib[r_idx];

    nibble_sub u_stage (
        .x  (w_x),
        .y  (w_y),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = start ? RUN : IDLE;
            RUN:     w_state_next = w_last ? DONE : RUN;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
        end else if (r_state == RUN) begin
            r_work   <= w_work_next;
            r_borrow <= w_bo;
            r_idx    <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_diff <= w_work_next;
                r_bout <= w_bo;
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule
